// File: rtl/opp_mc_pkg.sv
// Shared types and helpers for the multi-channel output preprocessor.
package opp_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MULT  = 3'd1,
    ST_ACC   = 3'd2,
    ST_LIMIT = 3'd3,
    ST_SEND  = 3'd4
  } state_e;

  localparam logic [2:0] PA_MAX  = 3'd0;
  localparam logic [2:0] PA_MIN  = 3'd1;
  localparam logic [2:0] PA_INIT = 3'd2;
  localparam logic [2:0] PA_MULT = 3'd3;
  localparam logic [2:0] PA_SLEW = 3'd4;

  // Signed saturation of a 64-bit intermediate into a w-bit signed range.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      sat = hi;
    else if (v < lo) sat = lo;
    else             sat = v;
  endfunction

endpackage

// File: rtl/output_preprocessor_mc_if.sv
// Sample, parameter and output bus of the multi-channel output preprocessor.
interface output_preprocessor_mc_if #(
  parameter int N_CHAN = 8,
  parameter int W_CHAN = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
  parameter int W_IN   = 18,
  parameter int W_OUT  = 16
);
  logic signed [W_IN-1:0]  data_in;
  logic [W_CHAN-1:0]       chan_in;
  logic                    data_valid_in;
  logic                    ready_out;
  logic [N_CHAN-1:0]       lock_en_in;
  logic                    param_wr_en_in;
  logic [W_CHAN-1:0]       param_chan_in;
  logic [2:0]              param_addr_in;
  logic [W_OUT-1:0]        param_data_in;
  logic                    update_en_in;
  logic                    update_in;
  logic signed [W_OUT-1:0] data_out;
  logic [W_CHAN-1:0]       chan_out;
  logic                    data_valid_out;
  logic                    chan_err_out;

  modport master (
    output data_in, chan_in, data_valid_in, lock_en_in, param_wr_en_in, param_chan_in,
           param_addr_in, param_data_in, update_en_in, update_in,
    input  ready_out, data_out, chan_out, data_valid_out, chan_err_out
  );

  modport slave (
    input  data_in, chan_in, data_valid_in, lock_en_in, param_wr_en_in, param_chan_in,
           param_addr_in, param_data_in, update_en_in, update_in,
    output ready_out, data_out, chan_out, data_valid_out, chan_err_out
  );
endinterface

// File: rtl/opp_param_bank.sv
// Per-channel shadow/active parameter storage with atomic shadow-to-active copy.
module opp_param_bank
  import opp_mc_pkg::*;
#(
  parameter int N_CHAN     = 8,
  parameter int W_CHAN     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
  parameter int W_OUT      = 16,
  parameter int W_MULT     = 8,
  parameter int OMAX_INIT  = 9999,
  parameter int OMIN_INIT  = 1111,
  parameter int OINIT_INIT = 5000,
  parameter int MULT_INIT  = 1,
  parameter int SLEW_INIT  = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          wr_en_i,
  input  logic [W_CHAN-1:0]             wr_chan_i,
  input  logic [2:0]                    wr_addr_i,
  input  logic [W_OUT-1:0]              wr_data_i,
  input  logic                          copy_i,
  input  logic [W_CHAN-1:0]             rd_chan_i,
  output logic [W_OUT-1:0]              max_o,
  output logic [W_OUT-1:0]              min_o,
  output logic [W_OUT-1:0]              init_o,
  output logic [W_MULT-1:0]             mult_o,
  output logic [W_OUT-1:0]              slew_o,
  output logic [N_CHAN-1:0][W_OUT-1:0]  shd_init_o
);
  logic [N_CHAN-1:0][W_OUT-1:0]  smax_q, smin_q, sinit_q, sslew_q;
  logic [N_CHAN-1:0][W_OUT-1:0]  amax_q, amin_q, ainit_q, aslew_q;
  logic [N_CHAN-1:0][W_MULT-1:0] smult_q, amult_q;
  logic                          wr_ok;

  assign wr_ok = wr_en_i && (32'(wr_chan_i) < N_CHAN);

  // Copy reads the pre-edge shadow, so a same-cycle write lands in shadow only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < N_CHAN; c++) begin
        smax_q[c]  <= W_OUT'(OMAX_INIT);   amax_q[c]  <= W_OUT'(OMAX_INIT);
        smin_q[c]  <= W_OUT'(OMIN_INIT);   amin_q[c]  <= W_OUT'(OMIN_INIT);
        sinit_q[c] <= W_OUT'(OINIT_INIT);  ainit_q[c] <= W_OUT'(OINIT_INIT);
        smult_q[c] <= W_MULT'(MULT_INIT);  amult_q[c] <= W_MULT'(MULT_INIT);
        sslew_q[c] <= W_OUT'(SLEW_INIT);   aslew_q[c] <= W_OUT'(SLEW_INIT);
      end
    end else begin
      if (wr_ok) begin
        case (wr_addr_i)
          PA_MAX:  smax_q[wr_chan_i]  <= wr_data_i;
          PA_MIN:  smin_q[wr_chan_i]  <= wr_data_i;
          PA_INIT: sinit_q[wr_chan_i] <= wr_data_i;
          PA_MULT: smult_q[wr_chan_i] <= wr_data_i[W_MULT-1:0];
          PA_SLEW: sslew_q[wr_chan_i] <= wr_data_i;
          default: ;
        endcase
      end
      if (copy_i) begin
        amax_q  <= smax_q;
        amin_q  <= smin_q;
        ainit_q <= sinit_q;
        amult_q <= smult_q;
        aslew_q <= sslew_q;
      end
    end
  end

  assign max_o      = amax_q[rd_chan_i];
  assign min_o      = amin_q[rd_chan_i];
  assign init_o     = ainit_q[rd_chan_i];
  assign mult_o     = amult_q[rd_chan_i];
  assign slew_o     = aslew_q[rd_chan_i];
  assign shd_init_o = sinit_q;

endmodule

// File: rtl/output_preprocessor_mc.sv
// Time-multiplexed lock output preprocessor: multiply/accumulate, lock-disable, slew, clamp.
module output_preprocessor_mc
  import opp_mc_pkg::*;
#(
  parameter int N_CHAN     = 8,
  parameter int W_CHAN     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
  parameter int W_IN       = 18,
  parameter int W_OUT      = 16,
  parameter int W_MULT     = 8,
  parameter int OMAX_INIT  = 9999,
  parameter int OMIN_INIT  = 1111,
  parameter int OINIT_INIT = 5000,
  parameter int MULT_INIT  = 1,
  parameter int SLEW_INIT  = 0
) (
  input logic                clk_in,
  input logic                reset_n_in,
  output_preprocessor_mc_if.slave bus
);
  state_e                       state_q;
  logic [W_CHAN-1:0]            ch_q, chan_out_q;
  logic signed [W_OUT-1:0]      lock_q, acc_q, data_out_q;
  logic                         dvo_q, err_q, pend_q;
  logic [N_CHAN-1:0][W_OUT-1:0] prev_q;

  logic [W_OUT-1:0]             a_max, a_min, a_init, a_slew;
  logic [W_MULT-1:0]            a_mult;
  logic [N_CHAN-1:0][W_OUT-1:0] shd_init;

  logic signed [W_OUT-1:0]      lock_in, prod_sat, sum_sat;
  logic signed [63:0]           prod_w, prev_w, sum_w, d_w, slew_w, max_w, min_w, lim_w;
  logic                         upd_req, copy, ready, chan_ok;

  assign upd_req = bus.update_in && bus.update_en_in;
  assign copy    = (state_q == ST_IDLE) && pend_q;
  assign ready   = (state_q == ST_IDLE) && !pend_q && !upd_req;
  assign chan_ok = 32'(bus.chan_in) < N_CHAN;

  generate
    if (W_OUT < W_IN) begin : g_trunc
      assign lock_in = bus.data_in[W_IN-1 -: W_OUT];
    end else begin : g_ext
      assign lock_in = W_OUT'($signed(bus.data_in));
    end
  endgenerate

  opp_param_bank #(
    .N_CHAN(N_CHAN), .W_CHAN(W_CHAN), .W_OUT(W_OUT), .W_MULT(W_MULT),
    .OMAX_INIT(OMAX_INIT), .OMIN_INIT(OMIN_INIT), .OINIT_INIT(OINIT_INIT),
    .MULT_INIT(MULT_INIT), .SLEW_INIT(SLEW_INIT)
  ) u_bank (
    .clk_i(clk_in), .rst_n_i(reset_n_in),
    .wr_en_i(bus.param_wr_en_in), .wr_chan_i(bus.param_chan_in),
    .wr_addr_i(bus.param_addr_in), .wr_data_i(bus.param_data_in),
    .copy_i(copy), .rd_chan_i(ch_q),
    .max_o(a_max), .min_o(a_min), .init_o(a_init), .mult_o(a_mult), .slew_o(a_slew),
    .shd_init_o(shd_init)
  );

  // All arithmetic at 64 bits; narrowing happens only through sat() or range-safe casts.
  always_comb begin
    prod_w   = 64'(lock_q) * 64'(signed'({1'b0, a_mult}));
    prod_sat = W_OUT'(sat(prod_w, W_OUT));
    prev_w   = 64'(signed'(prev_q[ch_q]));
    sum_w    = 64'(acc_q) + prev_w;
    sum_sat  = W_OUT'(sat(sum_w, W_OUT));
    d_w      = 64'(acc_q) - prev_w;
    slew_w   = signed'(64'(a_slew));
    max_w    = 64'(signed'(a_max));
    min_w    = 64'(signed'(a_min));
    lim_w    = 64'(acc_q);
    if (slew_w != 64'sd0 && (d_w > slew_w || d_w < -slew_w))
      lim_w = (d_w > 64'sd0) ? prev_w + slew_w : prev_w - slew_w;
    if (lim_w > max_w) lim_w = max_w;
    if (lim_w < min_w) lim_w = min_w;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      lock_q     <= '0;
      acc_q      <= '0;
      data_out_q <= '0;
      chan_out_q <= '0;
      dvo_q      <= 1'b0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      for (int c = 0; c < N_CHAN; c++) prev_q[c] <= W_OUT'(OINIT_INIT);
    end else begin
      dvo_q <= 1'b0;
      err_q <= 1'b0;
      if (upd_req)   pend_q <= 1'b1;
      else if (copy) pend_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (copy) prev_q <= shd_init;
          if (ready && bus.data_valid_in) begin
            if (chan_ok) begin
              ch_q    <= bus.chan_in;
              lock_q  <= lock_in;
              state_q <= ST_MULT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_MULT: begin
          acc_q   <= prod_sat;
          state_q <= ST_ACC;
        end
        ST_ACC: begin
          acc_q   <= bus.lock_en_in[ch_q] ? sum_sat : $signed(a_init);
          state_q <= ST_LIMIT;
        end
        ST_LIMIT: begin
          data_out_q <= W_OUT'(lim_w);
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          prev_q[ch_q] <= data_out_q;
          chan_out_q   <= ch_q;
          dvo_q        <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready_out      = ready;
  assign bus.data_out       = data_out_q;
  assign bus.chan_out       = chan_out_q;
  assign bus.data_valid_out = dvo_q;
  assign bus.chan_err_out   = err_q;

endmodule
